seg7_scan4: RTL and testbench
=============================

// Module: seg7_scan4
// PURPOSE
//  Downstream display stage for the counter blocks: accepts four hex/BCD digits plus
//  decimal points and time-multiplexes them onto one common-anode 4-digit 7-seg display.
//  Double-buffered input (shadow -> active at frame boundary) prevents mid-frame tearing.
//  Anti-ghost blanking gap per digit slot; optional leading-zero blanking.
// PARAMETERS
//  SLOT_CYC   50_000  CLK cycles per digit slot (1 kHz digit rate at 50 MHz); >= BLANK_CYC+2
//  BLANK_CYC  500     cycles at start of each slot with all anodes off
//  LZB        1       1 = blank leading zeros on digits 3..1; 0 = show all digits
// PORTS
//  CLK    in   1   system clock
//  RST    in   1   asynchronous reset, active-high
//  DIGITS in   16  DIGITS[4i+3:4i] = digit i (i=0 rightmost)
//  DP     in   4   DP[i]=1 lights decimal point of digit i
//  LOAD   in   1   1-cycle strobe: capture DIGITS/DP into shadow register
//  FRAME  out  1   1-cycle pulse when active register is updated (slot 3 -> slot 0)
//  nSEG   out  8   cathodes, active-low; [7]=dp, [6:0]=g..a
//  nAN    out  4   anodes, active-low; nAN[i]=0 selects digit i
// BEHAVIOUR
//  Reset (async): slot counter=0, digit index=0, state=BLANK, shadow=active=0,
//   nAN=4'b1111, nSEG=8'hFF, FRAME=0. Release: first slot is digit 0, starts with BLANK.
//  Slot counter counts 0..SLOT_CYC-1, then wraps; on wrap, index advances 0->1->2->3->0.
//  FSM per slot: BLANK while count < BLANK_CYC; SHOW for count BLANK_CYC..SLOT_CYC-1.
//  BLANK: nAN=1111, nSEG=FF. SHOW: nAN = ~(1<<index), nSEG = pattern(active digit[index]).
//  nAN/nSEG are registered: pins reflect the state/count of the previous cycle (1-cycle latency).
//  Shadow: LOAD=1 -> shadow <= {DP,DIGITS} next edge; LOAD ignored otherwise.
//  Frame boundary = cycle where index 3 wraps to 0: active <= shadow, FRAME=1 that cycle.
//   If LOAD coincides with boundary, active takes the new DIGITS/DP directly (bypass).
//  Decode (nSEG[6:0]) 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:58 8:00 9:10
//   A:08 b:03 C:46 d:21 E:06 F:0E; nSEG[7] = ~DP[index].
//  Leading-zero blank (LZB=1): digit 3 blanked if 0; digit 2 if d3==0&&d2==0; digit 1 if
//   d3..d1 all 0; digit 0 never blanked. Blanked digit: nSEG[6:0]=7F, anode still driven,
//   DP still honoured. Evaluated on active register.
//  Mid-operation RST: outputs go to reset values immediately (async), no glitch on nAN low.
//  No two anodes are ever low in the same cycle; an anode is never low during BLANK.
// TESTING
//  (bench uses SLOT_CYC=8, BLANK_CYC=2)
//  1 Reset: RST=1 -> nAN=1111, nSEG=FF, FRAME=0; release -> 2 blank cycles then nAN=1110.
//  2 LOAD DIGITS=16'h1234, DP=4'b0100, LZB=1 -> after next FRAME: slot0 nSEG=99, slot1 B0,
//    slot2 24 (dp lit: nSEG[7]=0), slot3 F9; anode sequence 1110,1101,1011,0111.
//  3 LOAD 16'h0005 -> digits 3..1 show nSEG=FF with anode low, digit 0 shows 92;
//    LZB=0 -> digits 3..1 show C0.
//  4 Tearing: LOAD 16'hAAAA mid-frame -> display keeps old value until FRAME, then 88s.
//  5 LOAD on FRAME cycle with 16'hFFFF -> same frame shows 8E on all digits (bypass).
//  6 Checker: every cycle popcount(~nAN)<=1; nAN=1111 during each BLANK window; FRAME
//    period = 4*SLOT_CYC = 32 cycles; async RST mid-SHOW forces 1111/FF before next edge.

Source files
------------

// File: rtl/seg7_scan4.sv
// Four-digit common-anode 7-segment scanner with double-buffered digits,
// a per-slot anti-ghost blanking gap and optional leading-zero blanking.
module seg7_scan4 #(
    parameter int SLOT_CYC  = 50_000,
    parameter int BLANK_CYC = 500,
    parameter bit LZB       = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    output logic        FRAME,
    output logic [7:0]  nSEG,
    output logic [3:0]  nAN
);

    localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(SLOT_CYC - 2);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    state_t        r_state;
    logic [19:0]   r_shadow;
    logic [19:0]   r_active;
    logic          r_frame;
    logic [7:0]    r_seg;
    logic [3:0]    r_an;

    logic [CW-1:0] w_cnt_next;
    logic          w_wrap;
    logic          w_boundary;
    state_t        w_state_next;
    logic [3:0]    w_digit;
    logic [3:0]    w_dp_vec;
    logic          w_dp;
    logic [3:0]    w_zero;
    logic          w_lz_blank;
    logic [7:0]    w_seg_next;
    logic [3:0]    w_an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        p = 7'h7F;
        case (d)
            4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
            4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h58;
            4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
            4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  4'hF: p = 7'h0E;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_boundary = w_wrap && (r_idx == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_frame <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_wrap)
                r_idx <= r_idx + 2'd1;
            // Raised one cycle early so FRAME is high during the boundary cycle itself.
            r_frame <= (r_idx == 2'd3) && (r_cnt == CNT_PRE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (LOAD)
                r_shadow <= {DP, DIGITS};
            if (w_boundary)
                r_active <= LOAD ? {DP, DIGITS} : r_shadow;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_BLANK;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (w_cnt_next < CNT_SHOW) ? ST_BLANK : ST_SHOW;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_digit    = r_active[{r_idx, 2'b00} +: 4];
        w_dp_vec   = r_active[19:16];
        w_dp       = w_dp_vec[r_idx];
        w_zero     = 4'b0000;
        w_lz_blank = 1'b0;
        w_seg_next = 8'hFF;
        w_an_next  = 4'hF;
        for (int i = 0; i < 4; i++)
            w_zero[i] = (r_active[4*i +: 4] == 4'h0);
        case (r_idx)
            2'd3:    w_lz_blank = w_zero[3];
            2'd2:    w_lz_blank = w_zero[3] & w_zero[2];
            2'd1:    w_lz_blank = w_zero[3] & w_zero[2] & w_zero[1];
            default: w_lz_blank = 1'b0;
        endcase
        if (r_state == ST_SHOW) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = {~w_dp, (LZB && w_lz_blank) ? 7'h7F : seg_decode(w_digit)};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_seg <= 8'hFF;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign FRAME = r_frame;
    assign nSEG  = r_seg;
    assign nAN   = r_an;

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4 with SLOT_CYC=8, BLANK_CYC=2; a cycle model
// checks anode sequencing, blanking windows and FRAME timing every cycle.
module tb_seg7_scan4;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] DIGITS;
    logic [3:0]  DP;
    logic        LOAD;
    logic        FRAME,  FRAME0;
    logic [7:0]  nSEG,   nSEG0;
    logic [3:0]  nAN,    nAN0;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan4 #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .LZB(1'b1)) u_dut (
        .CLK(CLK), .RST(RST), .DIGITS(DIGITS), .DP(DP), .LOAD(LOAD),
        .FRAME(FRAME), .nSEG(nSEG), .nAN(nAN)
    );

    seg7_scan4 #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .LZB(1'b0)) u_dut_nolzb (
        .CLK(CLK), .RST(RST), .DIGITS(DIGITS), .DP(DP), .LOAD(LOAD),
        .FRAME(FRAME0), .nSEG(nSEG0), .nAN(nAN0)
    );

    always #5 CLK = ~CLK;

    // Reference slot timing: pins show the state of the previous cycle.
    int   m_cnt, m_idx, m_idx_q;
    bit   m_show_q;
    logic [3:0] exp_an;
    logic       exp_frame;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_cnt <= 0; m_idx <= 0; m_idx_q <= 0; m_show_q <= 1'b0;
        end else begin
            m_show_q <= (m_cnt >= BLANK);
            m_idx_q  <= m_idx;
            if (m_cnt == SLOT - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx + 1) % 4;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            exp_an    = m_show_q ? ~(4'b0001 << m_idx_q) : 4'hF;
            exp_frame = (m_idx == 3) && (m_cnt == SLOT - 1);
            n_cmp++;
            if (nAN !== exp_an) begin
                n_bad++;
                $display("FAIL anode_seq @%0t: nAN=%b, required %b", $time, nAN, exp_an);
            end
            n_cmp++;
            if (FRAME !== exp_frame) begin
                n_bad++;
                $display("FAIL frame_timing @%0t: FRAME=%b, required %b", $time, FRAME, exp_frame);
            end
            n_cmp++;
            if ($countones(~nAN) > 1 || $countones(~nAN0) > 1) begin
                n_bad++;
                $display("FAIL one_hot_anode @%0t: nAN=%b nAN0=%b, required at most one low", $time, nAN, nAN0);
            end
            if (!m_show_q) begin
                n_cmp++;
                if (nSEG !== 8'hFF || nAN0 !== 4'hF) begin
                    n_bad++;
                    $display("FAIL blank_window @%0t: nSEG=%h nAN0=%b, required FF/1111", $time, nSEG, nAN0);
                end
            end
        end
    end

    task automatic load_digits(input logic [15:0] d, input logic [3:0] p);
        @(negedge CLK);
        DIGITS = d; DP = p; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    // Returns at the negedge on which FRAME is observed high.
    task automatic goto_frame();
        int t;
        t = 0;
        @(negedge CLK);
        while (FRAME !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_wait: FRAME=%b after %0d cycles, required 1", FRAME, t);
        end
    endtask

    // Called from the negedge after FRAME (first_gap=5) samples each slot's SHOW window.
    task automatic grab_frame(input int first_gap, output logic [3:0][7:0] seg,
                              output logic [3:0][7:0] seg0, output logic [3:0][3:0] an);
        repeat (first_gap) @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            seg[k]  = nSEG;
            seg0[k] = nSEG0;
            an[k]   = nAN;
            if (k < 3) repeat (SLOT) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; LOAD = 1'b0; DIGITS = 16'h0000; DP = 4'h0;
        #12;
        n_cmp++;
        if (nAN !== 4'hF || nSEG !== 8'hFF || FRAME !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: nAN=%b nSEG=%h FRAME=%b, required 1111/FF/0", nAN, nSEG, FRAME);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (c < 3 && nAN !== 4'hF) begin
                n_bad++;
                $display("FAIL reset_blank%0d: nAN=%b, required 1111", c, nAN);
            end else if (c == 3 && (nAN !== 4'b1110 || nSEG !== 8'hC0)) begin
                n_bad++;
                $display("FAIL reset_first_show: nAN=%b nSEG=%h, required 1110/C0", nAN, nSEG);
            end
        end
    endtask

    task automatic test_display();
        logic [3:0][7:0] seg, seg0, exp;
        logic [3:0][3:0] an;
        exp = {8'hF9, 8'h24, 8'hB0, 8'h99};
        load_digits(16'h1234, 4'b0100);
        goto_frame();
        grab_frame(5, seg, seg0, an);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seg[k] !== exp[k] || an[k] !== ~(4'b0001 << k)) begin
                n_bad++;
                $display("FAIL display_digit%0d: nSEG=%h nAN=%b, required %h/%b", k, seg[k], an[k], exp[k], ~(4'b0001 << k));
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0][7:0] seg, seg0, exp, exp0;
        logic [3:0][3:0] an;
        exp  = {8'hFF, 8'hFF, 8'hFF, 8'h92};
        exp0 = {8'hC0, 8'hC0, 8'hC0, 8'h92};
        load_digits(16'h0005, 4'b0000);
        goto_frame();
        grab_frame(5, seg, seg0, an);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seg[k] !== exp[k] || an[k] !== ~(4'b0001 << k)) begin
                n_bad++;
                $display("FAIL lzb_on_digit%0d: nSEG=%h nAN=%b, required %h/%b", k, seg[k], an[k], exp[k], ~(4'b0001 << k));
            end
            n_cmp++;
            if (seg0[k] !== exp0[k]) begin
                n_bad++;
                $display("FAIL lzb_off_digit%0d: nSEG=%h, required %h", k, seg0[k], exp0[k]);
            end
        end
    endtask

    task automatic test_tearing();
        logic [3:0][7:0] seg, seg0;
        logic [3:0][3:0] an;
        goto_frame();
        repeat (10) @(negedge CLK);
        DIGITS = 16'hAAAA; DP = 4'b0000; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        for (int k = 2; k < 4; k++) begin
            repeat (k == 2 ? 10 : SLOT) @(negedge CLK);
            n_cmp++;
            if (nSEG !== 8'hFF || nAN !== ~(4'b0001 << k)) begin
                n_bad++;
                $display("FAIL tearing_old%0d: nSEG=%h nAN=%b, required FF/%b", k, nSEG, nAN, ~(4'b0001 << k));
            end
        end
        goto_frame();
        grab_frame(5, seg, seg0, an);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seg[k] !== 8'h88) begin
                n_bad++;
                $display("FAIL tearing_new%0d: nSEG=%h, required 88", k, seg[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [3:0][7:0] seg, seg0;
        logic [3:0][3:0] an;
        goto_frame();
        DIGITS = 16'hFFFF; DP = 4'b0000; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        grab_frame(5, seg, seg0, an);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seg[k] !== 8'h8E) begin
                n_bad++;
                $display("FAIL bypass_digit%0d: nSEG=%h, required 8E", k, seg[k]);
            end
        end
        goto_frame();
        grab_frame(5, seg, seg0, an);
        n_cmp++;
        if (seg !== {4{8'h8E}}) begin
            n_bad++;
            $display("FAIL bypass_shadow: nSEG slots=%h, required 8E8E8E8E", seg);
        end
    endtask

    task automatic test_frame_period();
        int t;
        goto_frame();
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (FRAME !== 1'b1 && t < 100);
        n_cmp++;
        if (t !== 4 * SLOT) begin
            n_bad++;
            $display("FAIL frame_period: %0d cycles, required %0d", t, 4 * SLOT);
        end
    endtask

    task automatic test_async_reset();
        goto_frame();
        repeat (5) @(negedge CLK);
        n_cmp++;
        if (nAN !== 4'b1110) begin
            n_bad++;
            $display("FAIL pre_reset_show: nAN=%b, required 1110", nAN);
        end
        #1 RST = 1'b1;
        #1;
        n_cmp++;
        if (nAN !== 4'hF || nSEG !== 8'hFF || FRAME !== 1'b0 || nAN0 !== 4'hF) begin
            n_bad++;
            $display("FAIL async_reset: nAN=%b nSEG=%h FRAME=%b nAN0=%b, required 1111/FF/0/1111", nAN, nSEG, FRAME, nAN0);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (nAN !== 4'b1110 || nSEG !== 8'hC0) begin
            n_bad++;
            $display("FAIL reset_recover: nAN=%b nSEG=%h, required 1110/C0", nAN, nSEG);
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_lzb();
        test_tearing();
        test_bypass();
        test_frame_period();
        test_async_reset();
        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
